apu_reg_writer: RTL

Register-write front end for the APU channels. Parses a byte stream from the serial receiver into two-byte (address, data) write frames and maintains the APU register bank $4000–$400F, $4015 and $4017. It drives the register buses and the per-channel `reg_change` toggles that the pulse, triangle and noise channels edge-detect to trigger length-counter reload. It is the producer side of the channel register interface.

---
 rtl/apu_reg_writer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/apu_reg_writer.sv
// apu_reg_writer: parses (address, data) byte pairs from the serial receiver
// and maintains the APU register bank $4000-$400F, $4015 and $4017.
// Writes to the length-reload registers toggle a reg_change bit that
// the channel blocks edge-detect.
module apu_reg_writer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [127:0] reg_bank,
  output logic [7:0]   reg_4015,
  output logic [7:0]   reg_4017,
  output logic [4:0]   reg_change,
  output logic         wr_strobe,
  output logic [7:0]   err_count
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [4:0]       addr_q, addr_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [15:0][7:0] bank_q, bank_d;
  logic [7:0]       r4015_q, r4015_d;
  logic [7:0]       r4017_q, r4017_d;
  logic [4:0]       chg_q, chg_d;
  logic             strb_q, strb_d;
  logic [7:0]       err_q, err_d;
  logic             err_inc;
  logic [16:0]      tmo_nxt;

  // Frame parser: address latch, write decode, timeout and error accounting.
  // A data byte arriving on the expiry cycle is checked first, so it wins.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tmo_d   = tmo_q;
    bank_d  = bank_q;
    r4015_d = r4015_q;
    r4017_d = r4017_q;
    chg_d   = chg_q;
    strb_d  = 1'b0;
    err_inc = 1'b0;
    tmo_nxt = {1'b0, tmo_q} + 17'd1;
    if (state_q == S_IDLE) begin
      if (rx_valid) begin
        if (rx_data[7]) begin
          addr_d  = rx_data[4:0];
          tmo_d   = '0;
          state_d = S_WAIT;
        end else begin
          err_inc = 1'b1;
        end
      end
    end else begin
      if (rx_valid) begin
        state_d = S_IDLE;
        if (!addr_q[4]) begin
          bank_d[addr_q[3:0]] = rx_data;
          strb_d = 1'b1;
          // $4003/$4007/$400B/$400F map to toggle bits 0..3 via addr[3:2]
          if (addr_q[1:0] == 2'b11)
            chg_d[{1'b0, addr_q[3:2]}] = ~chg_q[{1'b0, addr_q[3:2]}];
        end else if (addr_q == 5'h15) begin
          r4015_d = rx_data;
          strb_d  = 1'b1;
        end else if (addr_q == 5'h17) begin
          r4017_d  = rx_data;
          strb_d   = 1'b1;
          chg_d[4] = ~chg_q[4];
        end else begin
          err_inc = 1'b1;
        end
      end else if (TIMEOUT_CYCLES != 0) begin
        if (tmo_nxt == 17'(TIMEOUT_CYCLES)) begin
          state_d = S_IDLE;
          tmo_d   = '0;
          err_inc = 1'b1;
        end else begin
          tmo_d = tmo_nxt[15:0];
        end
      end
    end
    err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  // State and output registers; everything clears on reset, abandoning any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      tmo_q   <= '0;
      bank_q  <= '0;
      r4015_q <= '0;
      r4017_q <= '0;
      chg_q   <= '0;
      strb_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
      bank_q  <= bank_d;
      r4015_q <= r4015_d;
      r4017_q <= r4017_d;
      chg_q   <= chg_d;
      strb_q  <= strb_d;
      err_q   <= err_d;
    end
  end

  assign reg_bank   = bank_q;
  assign reg_4015   = r4015_q;
  assign reg_4017   = r4017_q;
  assign reg_change = chg_q;
  assign wr_strobe  = strb_q;
  assign err_count  = err_q;

endmodule
